pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline sequencing controller for the 19-bit CPU: owns every PC and stage-register enable and flush in the IF/ID/EX/MEM/WB pipeline. It arbitrates between competing stall and flush sources: data-memory wait, HLT, taken branch and load-use hazard. It bounds memory waits with a timeout and keeps a saturating stall counter. It sits beside the register file and drives the enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- MEM_TIMEOUT, 16: number of consecutive stalled memory cycles before a fatal timeout; must be ≥2 and ≤255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_memread  in  1  the EX-stage instruction is a load.
- ex_rt  in  3  load destination register in EX.
- id_rs, id_rt  in  3 each  source registers of the ID instruction.
- id_uses_rt  in  1  the ID instruction reads rt.
- branch_taken  in  1  taken branch or jump resolved in EX.
- halt  in  1  HLT decoded in EX.
- resume  in  1  restart request while halted.
- mem_req, mem_ready  in  1 each  data-memory access in MEM, and its completion.
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  stage enables.
- ifid_flush, idex_flush  out  1 each  insert a bubble; a flush overrides the matching write.
- halted  out  1  state is HALTED.
- mem_err  out  1  sticky memory-timeout flag.
- stall_count  out  16  saturating count of stalled cycles.

## Operation
- States: RUN, MEM_WAIT, HALTED. Registers: state, wait_cnt[7:0], mem_err, stall_count.
- Enable and flush outputs are combinational from state, the inputs and rst_n.
- Defaults, unless a rule below overrides them: all writes 1, all flushes 0.
- freeze = mem_req && !mem_ready.
- lu = ex_memread && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- RUN applies the first matching rule, in this priority order:
  - freeze: all five writes 0; wait_cnt←1; next state MEM_WAIT.
  - halt: all writes 0; next state HALTED.
  - branch_taken: ifid_flush=1, idex_flush=1, pc_write=1 (target load). Any lu condition in the same cycle is ignored.
  - lu: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble; state stays RUN.
- MEM_WAIT:
  - mem_ready=1: RUN decode without freeze, so the data is captured this cycle; next state RUN.
  - mem_ready=0: all writes 0. If wait_cnt==MEM_TIMEOUT-1: mem_err←1 and next state HALTED. Otherwise wait_cnt++.
- HALTED:
  - All writes 0 and halted=1.
  - resume=1 with mem_err=0: pc_write=1, ifid_write=1, idex_flush=1 (squashes the HLT), exmem_write=1, memwb_write=1; next state RUN.
  - resume is ignored while mem_err=1. Only reset clears mem_err.
- stall_count: +1 on any cycle with pc_write=0 and state≠HALTED. It saturates at 0xFFFF and does not wrap.

## Timing
- Reset: on a rising edge with rst_n=0, state←RUN, wait_cnt←0, mem_err←0, stall_count←0.
- While rst_n=0, outputs are forced regardless of state: all writes 0, both flushes 1, halted=0.
- Reset mid-MEM_WAIT or mid-HALTED returns to RUN on that edge.
- The load-use bubble costs exactly 1 cycle. A taken branch costs 2 squashed instructions with zero stall cycles.
- A memory wait of N cycles (mem_ready arriving in stalled cycle N+1) costs N stall cycles, provided N<MEM_TIMEOUT.
- Timeout: the edge ending the MEM_TIMEOUT-th consecutive stalled cycle enters HALTED. mem_err and halted read 1 from the next cycle.
- mem_ready is sampled only while mem_req=1. mem_ready without mem_req is ignored.
- HLT entry: the cycle halt is seen has all writes 0; halted=1 from the next cycle.
- Resume: the cycle resume is seen issues the restart outputs; RUN from the next cycle.

## Test plan
- Load-use: ex_memread=1, ex_rt=3, id_rs=3 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle; stall_count=1.
- Branch vs load-use: branch_taken=1 and lu=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1; stall_count unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> 3 fully frozen cycles; all writes 1 on the ready cycle; state back in RUN; stall_count=3.
- Timeout with MEM_TIMEOUT=4: mem_ready never asserts -> HALTED after the 4th stalled cycle; mem_err=1; resume=1 ignored; rst_n=0 for one edge clears mem_err and returns to RUN.
- Halt/resume: halt=1 -> halted=1 next cycle. resume=1 after 5 cycles -> idex_flush=1, pc_write=1; RUN next cycle; stall_count counts only the entry cycle.
- Saturation: preload by running more than 65535 lu stalls -> stall_count holds 0xFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stage enable/flush outputs of the pipeline controller
interface pipeline_ctrl_if;
  logic ex_memread;
  logic [2:0] ex_rt, id_rs, id_rt;
  logic id_uses_rt, branch_taken, halt, resume, mem_req, mem_ready;
  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_flush, halted, mem_err;
  logic [15:0] stall_count;
  modport master (
    output ex_memread, ex_rt, id_rs, id_rt, id_uses_rt, branch_taken, halt, resume, mem_req, mem_ready,
    input pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush, idex_flush, halted, mem_err, stall_count
  );
  modport slave (
    input ex_memread, ex_rt, id_rs, id_rt, id_uses_rt, branch_taken, halt, resume, mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush, idex_flush, halted, mem_err, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: arbitrates memory wait, halt, branch and load-use into stage enables and flushes
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;
  state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic mem_err_q, err_nxt, freeze, done, lu;
  logic [15:0] stall_q;
  logic [4:0] wr;
  logic [1:0] fl;
  assign freeze = bus.mem_req && !bus.mem_ready;
  assign done = bus.mem_req && bus.mem_ready;
  assign lu = bus.ex_memread && (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
  always_comb begin
    state_nxt = (state == MEM_WAIT) ? RUN : state;
    wait_nxt = wait_cnt;
    err_nxt = mem_err_q;
    wr = '1;
    fl = '0;
    if (state == HALTED) begin
      wr = '0;
      if (bus.resume && !mem_err_q) begin
        wr = 5'b11011;
        fl = 2'b01;
        state_nxt = RUN;
      end
    end else if (state == MEM_WAIT && !done) begin
      wr = '0;
      if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
        err_nxt = 1'b1;
        state_nxt = HALTED;
      end else begin
        wait_nxt = wait_cnt + 8'd1;
        state_nxt = MEM_WAIT;
      end
    end else if (freeze) begin
      wr = '0;
      wait_nxt = 8'd1;
      state_nxt = MEM_WAIT;
    end else if (bus.halt) begin
      wr = '0;
      state_nxt = HALTED;
    end else if (bus.branch_taken) fl = 2'b11;
    else if (lu) begin
      wr = 5'b00111;
      fl = 2'b01;
    end
    // reset forces a safe bubble into every stage regardless of state
    if (!rst_n) begin
      wr = '0;
      fl = '1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_err_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err_q <= err_nxt;
      if (!wr[4] && state != HALTED && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.memwb_write} = wr;
  assign {bus.ifid_flush, bus.idex_flush} = fl;
  assign bus.halted = rst_n && state == HALTED;
  assign bus.mem_err = mem_err_q;
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: random and directed stimulus against a cycle-level behavioural model
module tb_pipeline_ctrl;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0;
  bit m_halted, m_err;
  int m_wait, m_stalls;
  pipeline_ctrl_if bus();
  pipeline_ctrl #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1;
    bus.ex_memread = 0; bus.ex_rt = 0; bus.id_rs = 1; bus.id_rt = 2; bus.id_uses_rt = 0;
    bus.branch_taken = 0; bus.halt = 0; bus.resume = 0; bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  // called just after a falling edge with inputs already driven
  task automatic step();
    logic [6:0] e;
    logic stalled, lu;
    #1;
    lu = bus.ex_memread && (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
    stalled = bus.mem_req ? !bus.mem_ready : (m_wait > 0);
    if (!rst_n) e = 7'b0000011;
    else if (m_halted) e = (bus.resume && !m_err) ? 7'b1101101 : 7'b0000000;
    else if (stalled || bus.halt) e = 7'b0000000;
    else if (bus.branch_taken) e = 7'b1111111;
    else if (lu) e = 7'b0011101;
    else e = 7'b1111100;
    check("outs", {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.memwb_write,
                   bus.ifid_flush, bus.idex_flush}, e);
    check("halted", bus.halted, rst_n && m_halted);
    check("mem_err", bus.mem_err, m_err);
    check("stall_count", bus.stall_count, m_stalls);
    @(posedge clk);
    if (!rst_n) begin
      m_halted = 0; m_err = 0; m_wait = 0; m_stalls = 0;
    end else begin
      if (!e[6] && !m_halted && m_stalls < 65535) m_stalls++;
      if (m_halted) begin
        if (bus.resume && !m_err) m_halted = 0;
      end else if (stalled) begin
        m_wait++;
        if (m_wait == T) begin
          m_err = 1; m_halted = 1; m_wait = 0;
        end
      end else begin
        m_wait = 0;
        if (bus.halt) m_halted = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_halted = 0; m_err = 0; m_wait = 0; m_stalls = 0;
    step();
    check("reset_stall", bus.stall_count, 0);
    // load-use bubble
    idle(); bus.ex_memread = 1; bus.ex_rt = 3; bus.id_rs = 3;
    step();
    check("lu_stall", bus.stall_count, 1);
    idle(); step();
    // branch wins over load-use
    bus.ex_memread = 1; bus.ex_rt = 5; bus.id_rt = 5; bus.id_uses_rt = 1; bus.branch_taken = 1;
    step();
    check("br_stall", bus.stall_count, 1);
    // three-cycle memory wait
    idle(); bus.mem_req = 1;
    repeat (3) step();
    bus.mem_ready = 1; step();
    check("mw_stall", bus.stall_count, 4);
    idle(); step();
    // timeout, resume ignored, reset clears
    bus.mem_req = 1;
    repeat (T) step();
    idle();
    check("to_err", bus.mem_err, 1);
    check("to_halted", bus.halted, 1);
    bus.resume = 1;
    repeat (2) step();
    rst_n = 0; step();
    idle();
    check("to_clear", bus.mem_err, 0);
    step();
    // halt then resume after five cycles
    bus.halt = 1; step();
    idle();
    check("hlt_halted", bus.halted, 1);
    repeat (5) step();
    bus.resume = 1; step();
    idle(); step();
    check("hlt_stall", bus.stall_count, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 64) != 0;
      bus.mem_req = ($urandom % 4) == 0;
      bus.mem_ready = $urandom % 2;
      bus.halt = ($urandom % 32) == 0;
      bus.resume = ($urandom % 4) == 0;
      bus.branch_taken = ($urandom % 8) == 0;
      bus.ex_memread = ($urandom % 3) == 0;
      bus.ex_rt = 3'($urandom_range(0, 7));
      bus.id_rs = 3'($urandom_range(0, 7));
      bus.id_rt = 3'($urandom_range(0, 7));
      bus.id_uses_rt = $urandom % 2;
      step();
    end
    // saturation
    idle(); rst_n = 0; step();
    idle(); bus.ex_memread = 1; bus.ex_rt = 3; bus.id_rs = 3;
    repeat (65540) step();
    check("sat", bus.stall_count, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
